// File: rtl/outputs_deskew_buffer_pkg.sv
// Shared definitions for the systolic edge buffers: state encoding,
// default geometry and the diagonal-to-row index helper.
package outputs_deskew_buffer_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_MATRIX_SIZE = 2;
   localparam int unsigned NUM_BEATS           = 2 * DEFAULT_MATRIX_SIZE - 1;

   typedef struct packed {
      logic        in_range;
      logic [31:0] row;
   } skew_t;

   // Beats needed to carry a full n x n matrix across the anti-diagonals.
   function automatic int unsigned num_beats(input int unsigned n);
      return 2 * n - 1;
   endfunction

   // Row of the element a column lane carries on a given beat; lanes whose
   // row falls outside 0..n-1 carry nothing useful on that beat.
   function automatic skew_t skew_row(input int unsigned beat,
                                      input int unsigned col,
                                      input int unsigned n);
      skew_t s;
      int    r;
      r          = int'(beat) - int'(col);
      s.in_range = (r >= 0) && (r < int'(n));
      s.row      = s.in_range ? 32'(r) : '0;
      return s;
   endfunction

endpackage

// File: rtl/outputs_deskew_buffer.sv
// Collects skewed result beats from the bottom row of the PE array,
// rebuilds the N x N matrix, then drains it row-major on a valid/ready stream.
module outputs_deskew_buffer
   import outputs_deskew_buffer_pkg::*;
#(
   parameter int unsigned MATRIX_SIZE = 2,
   parameter int unsigned DATA_WIDTH  = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    array_valid,
   input  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]  array_data,
   output logic                                    buffer_ready,
   output logic signed [DATA_WIDTH-1:0]            out_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_last,
   output logic                                    busy
);

   localparam int unsigned BEATS = num_beats(MATRIX_SIZE);
   localparam int unsigned BW    = $clog2(2 * MATRIX_SIZE);
   localparam int unsigned RW    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [RW-1:0] LAST_IDX  = RW'(MATRIX_SIZE - 1);

   state_t          state;
   state_t          state_next;
   logic [BW-1:0]   beat;
   logic [RW-1:0]   row;
   logic [RW-1:0]   col;
   logic [DATA_WIDTH-1:0] mat [MATRIX_SIZE][MATRIX_SIZE];

   logic            lane_hit [MATRIX_SIZE];
   logic [RW-1:0]   lane_row [MATRIX_SIZE];

   logic            accept;
   logic            final_beat;
   logic            take;
   logic            at_last;

   assign accept     = (state == COLLECT) && array_valid;
   assign final_beat = accept && (beat == LAST_BEAT);
   assign take       = (state == DRAIN) && out_ready;
   assign at_last    = (row == LAST_IDX) && (col == LAST_IDX);

   // Map each column lane of the current beat to its destination row.
   always_comb begin
      skew_t s;
      s = '0;
      for (int unsigned c = 0; c < MATRIX_SIZE; c++) begin
         s           = skew_row(32'(beat), c, MATRIX_SIZE);
         lane_hit[c] = s.in_range;
         lane_row[c] = RW'(s.row);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_next;
   end

   // Next-state: collect until the final diagonal, drain until the last handshake.
   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (final_beat)       state_next = DRAIN;
         DRAIN:   if (take && at_last)  state_next = COLLECT;
         default:                       state_next = COLLECT;
      endcase
   end

   // Beat counter, drain indices and matrix storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat <= '0;
         row  <= '0;
         col  <= '0;
         for (int unsigned r = 0; r < MATRIX_SIZE; r++) begin
            for (int unsigned c = 0; c < MATRIX_SIZE; c++) begin
               mat[r][c] <= '0;
            end
         end
      end else begin
         if (accept) begin
            for (int unsigned c = 0; c < MATRIX_SIZE; c++) begin
               if (lane_hit[c]) mat[lane_row[c]][c] <= array_data[c];
            end
            beat <= final_beat ? '0 : beat + 1'b1;
         end
         if (take) begin
            if (col == LAST_IDX) begin
               col <= '0;
               row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Outputs: handshake flags from state, data from the storage mux.
   always_comb begin
      buffer_ready = (state == COLLECT);
      out_valid    = (state == DRAIN);
      out_last     = (state == DRAIN) && at_last;
      busy         = (state == DRAIN) || ((state == COLLECT) && (beat != '0));
      out_data     = (state == DRAIN) ? mat[row][col] : '0;
   end

endmodule

// File: tb/tb_outputs_deskew_buffer.sv
// Bench for outputs_deskew_buffer at N=2 and N=3: diagonal beats are generated
// from a reference matrix and the drained stream is compared row-major.
module tb_outputs_deskew_buffer;

   localparam int SIG_BR = 0;
   localparam int SIG_OV = 1;
   localparam int SIG_OL = 2;
   localparam int SIG_BY = 3;
   localparam int SIG_OD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             av2, av3, ordy;
   logic [2:0][15:0] ad;

   logic        br2, ov2, ol2, by2;
   logic [15:0] od2;
   logic        br3, ov3, ol3, by3;
   logic [15:0] od3;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] m [3][3];

   outputs_deskew_buffer #(.MATRIX_SIZE(2), .DATA_WIDTH(16)) dut2 (
      .clk(clk), .rst(rst), .array_valid(av2), .array_data(ad[1:0]),
      .buffer_ready(br2), .out_data(od2), .out_valid(ov2),
      .out_ready(ordy), .out_last(ol2), .busy(by2)
   );

   outputs_deskew_buffer #(.MATRIX_SIZE(3), .DATA_WIDTH(16)) dut3 (
      .clk(clk), .rst(rst), .array_valid(av3), .array_data(ad),
      .buffer_ready(br3), .out_data(od3), .out_valid(ov3),
      .out_ready(ordy), .out_last(ol3), .busy(by3)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] obs(input int n, input int s);
      logic [31:0] v;
      v = '0;
      case (s)
         SIG_BR: v = (n == 2) ? 32'(br2) : 32'(br3);
         SIG_OV: v = (n == 2) ? 32'(ov2) : 32'(ov3);
         SIG_OL: v = (n == 2) ? 32'(ol2) : 32'(ol3);
         SIG_BY: v = (n == 2) ? 32'(by2) : 32'(by3);
         default: v = (n == 2) ? 32'(od2) : 32'(od3);
      endcase
      return v;
   endfunction

   task automatic set_v(input int n, input logic v);
      if (n == 2) av2 = v;
      else        av3 = v;
   endtask

   task automatic load_seq(input int n, input int base, input int stride);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            m[r][c] = 16'(base + stride * (r * n + c));
   endtask

   task automatic load_rand(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            m[r][c] = 16'($urandom);
   endtask

   // Send the first nb anti-diagonals of m; gaps: 0 none, 1 alternate, 2 random.
   task automatic feed(input int n, input int gaps, input int nb);
      for (int b = 0; b < nb; b++) begin
         int idle;
         idle = (gaps == 1 && b > 0) ? 1 : ((gaps == 2) ? int'($urandom_range(0, 2)) : 0);
         for (int k = 0; k < idle; k++) begin
            set_v(n, 1'b0);
            for (int c = 0; c < 3; c++) ad[c] = 16'($urandom);
            chk("idle_ready", obs(n, SIG_BR), 32'd1);
            chk("idle_busy", obs(n, SIG_BY), 32'(b != 0));
            step();
         end
         set_v(n, 1'b1);
         for (int c = 0; c < 3; c++) begin
            int r;
            r = b - c;
            ad[c] = (c < n && r >= 0 && r < n) ? m[r][c] : 16'($urandom);
         end
         chk("beat_ready", obs(n, SIG_BR), 32'd1);
         chk("beat_busy", obs(n, SIG_BY), 32'(b != 0));
         chk("beat_ovalid", obs(n, SIG_OV), 32'd0);
         step();
      end
      set_v(n, 1'b0);
   endtask

   // Drain and compare row-major; mode 0 always ready, 1 fixed stall pattern, 2 random.
   task automatic drain(input int n, input int mode, input logic inject);
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int idx;
      int cyc;
      int rdy;
      idx = 0;
      cyc = 0;
      while (idx < n * n && cyc < 100) begin
         rdy  = (mode == 0) ? 1 : ((mode == 1) ? pat[cyc % 7] : int'($urandom_range(0, 1)));
         ordy = (rdy != 0);
         set_v(n, inject);
         ad = {3{16'd99}};
         chk("drain_valid", obs(n, SIG_OV), 32'd1);
         chk("drain_bready", obs(n, SIG_BR), 32'd0);
         chk("drain_busy", obs(n, SIG_BY), 32'd1);
         chk("drain_data", obs(n, SIG_OD), 32'(m[idx / n][idx % n]));
         chk("drain_last", obs(n, SIG_OL), 32'(idx == n * n - 1));
         step();
         if (rdy != 0) idx++;
         cyc++;
      end
      chk("drain_count", 32'(idx), 32'(n * n));
      ordy = 1'b0;
      set_v(n, 1'b0);
      chk("post_bready", obs(n, SIG_BR), 32'd1);
      chk("post_ovalid", obs(n, SIG_OV), 32'd0);
      chk("post_last", obs(n, SIG_OL), 32'd0);
      chk("post_busy", obs(n, SIG_BY), 32'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int n = 2; n <= 3; n++) begin
         chk("rst_ovalid", obs(n, SIG_OV), 32'd0);
         chk("rst_odata", obs(n, SIG_OD), 32'd0);
         chk("rst_last", obs(n, SIG_OL), 32'd0);
         chk("rst_busy", obs(n, SIG_BY), 32'd0);
         chk("rst_bready", obs(n, SIG_BR), 32'd1);
      end
   endtask

   initial begin
      rst  = 1'b1;
      av2  = 1'b0;
      av3  = 1'b0;
      ordy = 1'b0;
      ad   = '0;
      step();
      step();
      pulse_rst();

      // N=2 basic, back-to-back beats and ready
      load_seq(2, 1, 1);
      feed(2, 0, 3);
      drain(2, 0, 1'b0);

      // gapped beats give the same stream
      feed(2, 1, 3);
      drain(2, 0, 1'b0);

      // stalled drain holds data
      feed(2, 0, 3);
      drain(2, 1, 1'b0);

      // beats offered during drain are ignored
      feed(2, 0, 3);
      drain(2, 0, 1'b1);
      load_seq(2, 5, 1);
      feed(2, 0, 3);
      drain(2, 0, 1'b0);

      // reset mid-collect drops the partial matrix
      load_seq(2, 77, 3);
      feed(2, 0, 2);
      pulse_rst();
      load_seq(2, 10, 10);
      feed(2, 0, 3);
      drain(2, 0, 1'b0);

      // N=3 sequential matrix
      load_seq(3, 1, 1);
      feed(3, 0, 5);
      drain(3, 0, 1'b0);

      // reset mid-drain
      load_rand(3);
      feed(3, 0, 5);
      ordy = 1'b1;
      step();
      ordy = 1'b0;
      pulse_rst();
      load_seq(3, 100, 7);
      feed(3, 1, 5);
      drain(3, 1, 1'b0);

      // randomized matrices, gaps, ready and injection
      for (int i = 0; i < 6; i++) begin
         load_rand(2);
         feed(2, 2, 3);
         drain(2, 2, 1'($urandom_range(0, 1)));
         load_rand(3);
         feed(3, 2, 5);
         drain(3, 2, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
